// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_pipe_pkg
// Brief    : Constants, payload field layout and update-action encoding shared
//            by every inter-stage pipeline buffer instance.
// Revision : 1.0
// ============================================================================
package cpu_pipe_pkg;

    localparam logic [15:0] C_NOP_INSTR  = 16'b1110100000000000;
    localparam logic [15:0] C_HALT_INSTR = 16'b1110000000000000;

    // Payload layout, MSB first: NEXTPC | DATA1 | DATA2 | SIGNEXT | TRUEPC
    localparam int C_FIELD_W     = 16;
    localparam int C_TRUEPC_LSB  = 0;
    localparam int C_SIGNEXT_LSB = 16;
    localparam int C_DATA2_LSB   = 32;
    localparam int C_DATA1_LSB   = 48;
    localparam int C_NEXTPC_LSB  = 64;
    localparam int C_PAYLOAD_W   = 80;

    typedef logic [1:0] occ_t;

    // Edge action after priority resolution (reset is handled separately)
    localparam logic [2:0] ACT_NORMAL = 3'd0;
    localparam logic [2:0] ACT_STALL  = 3'd1;
    localparam logic [2:0] ACT_FLUSH  = 3'd2;
    localparam logic [2:0] ACT_HOLD   = 3'd3;
    localparam logic [2:0] ACT_HALT   = 3'd4;

    function automatic logic [C_PAYLOAD_W-1:0] pack_payload(
        input logic [C_FIELD_W-1:0] nextpc,
        input logic [C_FIELD_W-1:0] data1,
        input logic [C_FIELD_W-1:0] data2,
        input logic [C_FIELD_W-1:0] signext,
        input logic [C_FIELD_W-1:0] truepc
    );
        return {nextpc, data1, data2, signext, truepc};
    endfunction

    function automatic logic [C_FIELD_W-1:0] payload_field(
        input logic [C_PAYLOAD_W-1:0] payload,
        input int                     lsb
    );
        return payload[lsb +: C_FIELD_W];
    endfunction

endpackage : cpu_pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_slot
// Brief    : One-entry holding register with load, clear and valid flag.
// Revision : 1.0
// ============================================================================
module pipe_skid_slot #(
    parameter int ENTRY_W = 96
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [ENTRY_W-1:0] i_data,
    output logic               o_valid,
    output logic [ENTRY_W-1:0] o_data
);
    import cpu_pipe_pkg::*;

    logic               r_valid_q;
    logic               w_valid_d;
    logic [ENTRY_W-1:0] r_data_q;
    logic [ENTRY_W-1:0] w_data_d;

    // Clear dominates load so a drain and a refill can never collide
    always_comb begin
        w_valid_d = r_valid_q;
        w_data_d  = r_data_q;
        if (i_clear) begin
            w_valid_d = 1'b0;
            w_data_d  = '0;
        end else if (i_load) begin
            w_valid_d = 1'b1;
            w_data_d  = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_data_q  <= w_data_d;
        end
    end

    assign o_valid = r_valid_q;
    assign o_data  = r_data_q;

endmodule : pipe_skid_slot
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : Valid/ready inter-stage pipeline register with optional skid slot,
//            flush bubble insertion and sticky halt injection.
// Revision : 1.0
// ============================================================================
module pipe_stage_buf #(
    parameter int                 DATA_W     = 80,
    parameter int                 INSTR_W    = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(cpu_pipe_pkg::C_NOP_INSTR),
    parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(cpu_pipe_pkg::C_HALT_INSTR),
    parameter bit                 SKID       = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               stall,
    input  logic               flush,
    input  logic               halt,
    output logic               halted,
    output logic [1:0]         occupancy
);
    import cpu_pipe_pkg::*;

    localparam int C_ENTRY_W = DATA_W + INSTR_W;

    logic               r_out_valid_q;
    logic               w_out_valid_d;
    logic [DATA_W-1:0]  r_out_data_q;
    logic [DATA_W-1:0]  w_out_data_d;
    logic [INSTR_W-1:0] r_out_instr_q;
    logic [INSTR_W-1:0] w_out_instr_d;
    logic               r_halted_q;
    logic               w_halted_d;

    logic [2:0]         w_act;
    logic               w_in_ready_base;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_out_load;
    logic               w_skid_valid;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic [C_ENTRY_W-1:0] w_skid_entry;
    logic [DATA_W-1:0]  w_skid_data;
    logic [INSTR_W-1:0] w_skid_instr;
    occ_t               w_occ;

    generate
        if (SKID) begin : g_skid
            pipe_skid_slot #(
                .ENTRY_W (C_ENTRY_W)
            ) u_skid_slot (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_data  ({in_data, in_instr}),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_entry)
            );
            // Upstream ready comes straight from the skid flop, not from out_ready
            assign w_in_ready_base = !w_skid_valid;
        end else begin : g_no_skid
            assign w_skid_valid    = 1'b0;
            assign w_skid_entry    = '0;
            assign w_in_ready_base = !r_out_valid_q | out_ready;
        end
    endgenerate

    assign w_skid_data  = w_skid_entry[C_ENTRY_W-1:INSTR_W];
    assign w_skid_instr = w_skid_entry[INSTR_W-1:0];

    always_comb begin
        w_act = ACT_NORMAL;
        if (halt) begin
            w_act = ACT_HALT;
        end else if (r_halted_q) begin
            w_act = ACT_HOLD;
        end else if (flush) begin
            w_act = ACT_FLUSH;
        end else if (stall) begin
            w_act = ACT_STALL;
        end
    end

    assign in_ready   = w_in_ready_base & !stall & !r_halted_q;
    assign w_in_xfer  = in_valid & in_ready & (w_act == ACT_NORMAL);
    assign w_out_xfer = r_out_valid_q & out_ready & (w_act == ACT_NORMAL);
    assign w_out_load = w_out_xfer | !r_out_valid_q;

    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_out_data_d  = r_out_data_q;
        w_out_instr_d = r_out_instr_q;
        w_halted_d    = r_halted_q;
        w_skid_load   = 1'b0;
        w_skid_clear  = 1'b0;
        case (w_act)
            ACT_HALT: begin
                w_out_valid_d = 1'b1;
                w_out_data_d  = '0;
                w_out_instr_d = HALT_INSTR;
                w_halted_d    = 1'b1;
                w_skid_clear  = 1'b1;
            end
            ACT_FLUSH: begin
                w_out_valid_d = 1'b0;
                w_out_data_d  = '0;
                w_out_instr_d = NOP_INSTR;
                w_skid_clear  = 1'b1;
            end
            ACT_NORMAL: begin
                if (w_out_load) begin
                    // Older skid entry always leaves before the incoming one
                    if (w_skid_valid) begin
                        w_out_valid_d = 1'b1;
                        w_out_data_d  = w_skid_data;
                        w_out_instr_d = w_skid_instr;
                        w_skid_clear  = 1'b1;
                    end else if (w_in_xfer) begin
                        w_out_valid_d = 1'b1;
                        w_out_data_d  = in_data;
                        w_out_instr_d = in_instr;
                    end else begin
                        w_out_valid_d = 1'b0;
                        w_out_data_d  = '0;
                        w_out_instr_d = NOP_INSTR;
                    end
                end else if (w_in_xfer) begin
                    w_skid_load = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
            r_out_instr_q <= NOP_INSTR;
            r_halted_q    <= 1'b0;
        end else begin
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
            r_out_instr_q <= w_out_instr_d;
            r_halted_q    <= w_halted_d;
        end
    end

    assign w_occ     = occ_t'({1'b0, r_out_valid_q}) + occ_t'({1'b0, w_skid_valid});
    assign occupancy = w_occ;
    assign out_valid = r_out_valid_q;
    assign out_data  = r_out_data_q;
    assign out_instr = r_out_instr_q;
    assign halted    = r_halted_q;

endmodule : pipe_stage_buf
`default_nettype wire
